// File: rtl/fifomem_ctrl.sv
// ---------------------------------------------------------------------------
// fifomem_ctrl
//
// Pointer, flag and output-staging controller that runs an external
// fifomem storage array as a single-clock first-word-fall-through FIFO.
// The writer's data goes straight to the array's wdata. This block only
// produces the write enable and the two addresses. The array's
// combinational read data is captured into an output register, which
// feeds a valid/ready consumer interface.
//
// Parameters:
//   DSIZE      data width (must match the array)
//   ASIZE      address width, DEPTH = 1 << ASIZE
//   AF_THRESH  almost_full asserts when level >= AF_THRESH (1..DEPTH+1)
//
// Ports:
//   wclk, rst     clock (rising edge), synchronous active-high reset
//   wr_en         producer write request
//   wr_ready      array has space (= !full)
//   mem_wclken    array write enable
//   mem_waddr     array write address
//   mem_raddr     array read address
//   mem_rdata     array combinational read data
//   rd_data       head-of-FIFO data (output register)
//   rd_valid      rd_data is valid
//   rd_ready      consumer accepts rd_data
//   full          array holds DEPTH entries
//   empty         array and output register both empty
//   almost_full   level >= AF_THRESH
//   level         entries held in array + output register, 0..DEPTH+1
//
// Optional feature (macro FIFOMEM_CTRL_ERR_EN):
//   err_clr       clears the sticky error flags
//   err[0]        overflow  : wr_en while full
//   err[1]        underflow : rd_ready with nothing held anywhere
// ---------------------------------------------------------------------------
module fifomem_ctrl #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AF_THRESH = (1 << ASIZE) - 2
) (
    input  logic             wclk,
    input  logic             rst,
    input  logic             wr_en,
    output logic             wr_ready,
    output logic             mem_wclken,
    output logic [ASIZE-1:0] mem_waddr,
    output logic [ASIZE-1:0] mem_raddr,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic [DSIZE-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [ASIZE:0]   level
`ifdef FIFOMEM_CTRL_ERR_EN
    ,
    input  logic             err_clr,
    output logic [1:0]       err
`endif
);

    localparam logic [ASIZE:0] DEPTH  = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] AF_LVL = (ASIZE + 1)'(AF_THRESH);

    // Pointers carry one extra MSB so that a full array (difference DEPTH)
    // and an empty array (difference 0) stay distinguishable after wrap.
    logic [ASIZE:0]   wptr_reg;
    logic [ASIZE:0]   rptr_reg;
    logic             rd_valid_reg;
    logic [DSIZE-1:0] rd_data_reg;

    logic [ASIZE:0]   mcnt;
    logic             load;

    assign mcnt = wptr_reg - rptr_reg;

    assign full        = (mcnt == DEPTH);
    assign empty       = (mcnt == '0) && !rd_valid_reg;
    assign level       = mcnt + {{ASIZE{1'b0}}, rd_valid_reg};
    assign almost_full = (level >= AF_LVL);

    // The write side looks only at the array occupancy, not at a same-cycle
    // read, so wr_ready has no combinational path from rd_ready.
    assign wr_ready   = !full;
    assign mem_wclken = wr_en && !full && !rst;
    assign mem_waddr  = wptr_reg[ASIZE-1:0];
    assign mem_raddr  = rptr_reg[ASIZE-1:0];

    // Refill the output register whenever it is empty or being drained this
    // cycle. On a simultaneous write the array update lands at the edge, so
    // the combinational mem_rdata sampled here is still the old head.
    assign load = (mcnt != '0) && (!rd_valid_reg || rd_ready);

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;

    always_ff @(posedge wclk) begin
        if (rst) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            if (mem_wclken) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (load) begin
                rd_data_reg  <= mem_rdata;
                rd_valid_reg <= 1'b1;
                rptr_reg     <= rptr_reg + 1'b1;
            end else if (rd_valid_reg && rd_ready) begin
                rd_valid_reg <= 1'b0;
            end
        end
    end

`ifdef FIFOMEM_CTRL_ERR_EN
    logic [1:0] err_set;

    assign err_set[0] = wr_en && full;
    assign err_set[1] = rd_ready && !rd_valid_reg && (mcnt == '0);

    // One sticky flag per event; a set in the same cycle as err_clr wins.
    for (genvar gi = 0; gi < 2; gi++) begin : g_err
        logic flag_reg;

        always_ff @(posedge wclk) begin
            if (rst) begin
                flag_reg <= 1'b0;
            end else if (err_set[gi]) begin
                flag_reg <= 1'b1;
            end else if (err_clr) begin
                flag_reg <= 1'b0;
            end
        end

        assign err[gi] = flag_reg;
    end
`endif

endmodule

// File: tb/tb_fifomem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifomem_ctrl
//
// Scoreboard bench for fifomem_ctrl with a behavioural model of the storage
// array. Every accepted write pushes its data into a queue of expected
// values. A negedge monitor pops that queue on each rd_valid/rd_ready
// handshake and compares rd_data with the popped value. The monitor also
// compares the flags against an occupancy model that counts array entries
// and tracks whether the output register is holding data.
// ---------------------------------------------------------------------------
module tb_fifomem_ctrl;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 1 << ASIZE;
    localparam int AF    = DEPTH - 2;

    logic             wclk;
    logic             rst;
    logic             wr_en;
    logic             wr_ready;
    logic             mem_wclken;
    logic [ASIZE-1:0] mem_waddr;
    logic [ASIZE-1:0] mem_raddr;
    logic [DSIZE-1:0] mem_rdata;
    logic [DSIZE-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [ASIZE:0]   level;
    logic [DSIZE-1:0] wdata;
`ifdef FIFOMEM_CTRL_ERR_EN
    logic             err_clr;
    logic [1:0]       err;
    logic [1:0]       m_err;
`endif

    fifomem_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AF_THRESH(AF)) dut (
        .wclk        (wclk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_ready    (wr_ready),
        .mem_wclken  (mem_wclken),
        .mem_waddr   (mem_waddr),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .level       (level)
`ifdef FIFOMEM_CTRL_ERR_EN
        ,
        .err_clr     (err_clr),
        .err         (err)
`endif
    );

    // Storage array: synchronous write, combinational read.
    logic [DSIZE-1:0] mem [DEPTH];
    always @(posedge wclk) if (mem_wclken) mem[mem_waddr] <= wdata;
    assign mem_rdata = mem[mem_raddr];

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;
    int nreads = 0;
    bit started = 0;
    logic [DSIZE-1:0] exp_q[$];

    // Reference model: count of entries in the array, whether the output
    // register holds an item, and how many writes have been accepted.
    int m_cnt    = 0;
    bit m_valid  = 0;
    int m_wcount = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge wclk) begin
        bit acc, ld;
        if (rst) begin
            m_cnt    <= 0;
            m_valid  <= 0;
            m_wcount <= 0;
`ifdef FIFOMEM_CTRL_ERR_EN
            m_err    <= 2'b00;
`endif
        end else begin
            acc = wr_en && (m_cnt != DEPTH);
            ld  = (m_cnt != 0) && (!m_valid || rd_ready);
            m_cnt <= m_cnt + int'(acc) - int'(ld);
            if (ld) m_valid <= 1;
            else if (m_valid && rd_ready) m_valid <= 0;
            if (acc) m_wcount <= m_wcount + 1;
`ifdef FIFOMEM_CTRL_ERR_EN
            m_err <= {rd_ready && !m_valid && (m_cnt == 0), wr_en && (m_cnt == DEPTH)}
                     | (err_clr ? 2'b00 : m_err);
`endif
        end
    end

    // Monitor: one line per handshake, flag checks every cycle.
    always @(negedge wclk) begin
        if (started) begin
            chk("level", int'(level), m_cnt + int'(m_valid));
            chk("full", int'(full), int'(m_cnt == DEPTH));
            chk("empty", int'(empty), int'(m_cnt == 0 && !m_valid));
            chk("almost_full", int'(almost_full), int'(m_cnt + int'(m_valid) >= AF));
            chk("rd_valid", int'(rd_valid), int'(m_valid));
            chk("wr_ready", int'(wr_ready), int'(m_cnt != DEPTH));
            chk("mem_wclken", int'(mem_wclken), int'(wr_en && !rst && m_cnt != DEPTH));
            if (mem_wclken) chk("mem_waddr", int'(mem_waddr), m_wcount % DEPTH);
`ifdef FIFOMEM_CTRL_ERR_EN
            chk("err", int'(err), int'(m_err));
`endif
            if (!rst && rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_on_empty_scoreboard", 1, 0);
                end else begin
                    logic [DSIZE-1:0] e;
                    e = exp_q.pop_front();
                    $display("read %0d data=%02h expected=%02h", nreads, rd_data, e);
                    chk("rd_data", int'(rd_data), int'(e));
                end
                nreads++;
            end
        end
    end

    task automatic step(input logic we, input logic [DSIZE-1:0] d,
                        input logic rr, input logic r);
        wr_en    = we;
        wdata    = d;
        rd_ready = rr;
        rst      = r;
        if (r) exp_q.delete();
        else if (we && m_cnt != DEPTH) exp_q.push_back(d);
        @(posedge wclk);
        #1;
    endtask

    initial begin
        int n0;
        wr_en = 0; wdata = 0; rd_ready = 0; rst = 1;
`ifdef FIFOMEM_CTRL_ERR_EN
        err_clr = 0;
`endif
        @(posedge wclk);
        #1;
        started = 1;
        step(0, 8'h00, 0, 1);
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_level", int'(level), 0);

        // Idle after reset.
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0);

        // Single write, held until the consumer takes it.
        step(1, 8'hA5, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0);
        chk("t2_rd_data_held", int'(rd_data), 8'hA5);
        step(0, 8'h00, 1, 0);

        // Fill to DEPTH+1 and push once more while full.
        for (int i = 0; i < 18; i++) step(1, 8'($urandom), 0, 0);
        chk("t3_level", int'(level), DEPTH + 1);
        chk("t3_full", int'(full), 1);
`ifdef FIFOMEM_CTRL_ERR_EN
        chk("t3_overflow", int'(err[0]), 1);
        err_clr = 1;
        step(0, 8'h00, 0, 0);
        err_clr = 0;
`endif

        // Simultaneous write and read while full.
        for (int i = 0; i < 10; i++) step(1, 8'($urandom), 1, 0);
        for (int i = 0; i < 25; i++) step(0, 8'h00, 1, 0);
        chk("t5_drained", int'(empty), 1);

        // Streaming 0..39 with the consumer always ready.
        n0 = nreads;
        for (int i = 0; i < 40; i++) step(1, 8'(i), 1, 0);
        for (int i = 0; i < 2; i++) step(0, 8'h00, 1, 0);
        chk("t4_reads", nreads - n0, 40);

        // Reset with nine entries held, then check that no stale data survives.
        for (int i = 0; i < 9; i++) step(1, 8'($urandom), 0, 0);
        chk("t6_level_pre", int'(level), 9);
        step(0, 8'h00, 0, 1);
        chk("t6_level", int'(level), 0);
        chk("t6_empty", int'(empty), 1);
        step(1, 8'h3C, 0, 0);
        step(0, 8'h00, 0, 0);
        chk("t6_head", int'(rd_data), 8'h3C);
        step(0, 8'h00, 1, 0);

        // Randomised traffic with varying write/read pressure.
        for (int blk = 0; blk < 15; blk++) begin
            int pw, pr;
            pw = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            for (int i = 0; i < 100; i++) begin
`ifdef FIFOMEM_CTRL_ERR_EN
                err_clr = ($urandom_range(0, 19) == 0);
`endif
                step($urandom_range(0, 99) < pw, 8'($urandom),
                     $urandom_range(0, 99) < pr, $urandom_range(0, 299) == 0);
            end
        end
`ifdef FIFOMEM_CTRL_ERR_EN
        err_clr = 0;
`endif

        for (int i = 0; i < 30; i++) step(0, 8'h00, 1, 0);
        chk("final_scoreboard_left", exp_q.size(), 0);
        chk("final_empty", int'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
